// File: rtl/rand_pkg.sv
// Shared types and default constants for the range-reduced random picker.
package rand_pkg;

    // Controller states: wait for a request, fold the sample into range,
    // screen it against recent outputs, then hold the result for the consumer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } rand_state_t;

    localparam int RAND_WIDTH     = 10;
    localparam int RAND_RANGE     = 600;
    localparam int RAND_HISTORY   = 4;
    localparam int RAND_MAX_TRIES = 8;

    // Bits needed to count samples 1..max_tries inclusive.
    function automatic int tries_width(input int max_tries);
        return (max_tries < 2) ? 1 : $clog2(max_tries + 1);
    endfunction

endpackage

// File: rtl/rand_history_buf.sv
// Shift register of the most recently accepted outputs, each entry with a
// live bit, plus a parallel "query word equals any live entry" comparator.
module rand_history_buf
    import rand_pkg::*;
#(
    parameter int WIDTH = RAND_WIDTH,
    parameter int DEPTH = RAND_HISTORY
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_word,
    input  logic [WIDTH-1:0] query,
    output logic             match
);

    logic [DEPTH-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] word_reg;
            logic             live_reg;

            if (gi == 0) begin : g_head
                // Newest entry: loaded directly from the pushed word.
                always_ff @(posedge Clock) begin
                    if (Reset) begin
                        word_reg <= '0;
                        live_reg <= 1'b0;
                    end else if (push) begin
                        word_reg <= push_word;
                        live_reg <= 1'b1;
                    end
                end
            end else begin : g_tail
                // Older entries: shift down one slot on every push; the last
                // slot's previous contents fall off the end.
                always_ff @(posedge Clock) begin
                    if (Reset) begin
                        word_reg <= '0;
                        live_reg <= 1'b0;
                    end else if (push) begin
                        word_reg <= g_entry[gi-1].word_reg;
                        live_reg <= g_entry[gi-1].live_reg;
                    end
                end
            end

            // Only entries that have actually been written may cause a reject.
            assign hit[gi] = live_reg && (word_reg == query);
        end
    endgenerate

    assign match = |hit;

endmodule

// File: rtl/rand_range_picker.sv
// Reduces the free-running LFSR word into [0, RANGE) by repeated subtraction,
// resamples when the result repeats a recent output (bounded by MAX_TRIES),
// and hands the result to the consumer over a valid/ack handshake.
module rand_range_picker
    import rand_pkg::*;
#(
    parameter int WIDTH     = RAND_WIDTH,
    parameter int RANGE     = RAND_RANGE,
    parameter int HISTORY   = RAND_HISTORY,
    parameter int MAX_TRIES = RAND_MAX_TRIES
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] rnd_in,
    input  logic             req,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] value,
    output logic             forced,
    input  logic             ack
);

    localparam int TW = tries_width(MAX_TRIES);

    // One extra bit so that RANGE = 2^WIDTH is representable and the
    // compare/subtract never wraps.
    localparam logic [WIDTH:0]  RANGE_W = (WIDTH+1)'(RANGE);
    localparam logic [TW-1:0]   MAX_T   = TW'(MAX_TRIES);
    localparam logic [TW-1:0]   ONE_T   = TW'(1);

    rand_state_t      state_reg,  state_next;
    logic [WIDTH:0]   work_reg,   work_next;
    logic [TW-1:0]    tries_reg,  tries_next;
    logic [WIDTH-1:0] value_reg,  value_next;
    logic             forced_reg, forced_next;
    logic             valid_reg,  valid_next;

    logic             hist_match;
    logic             hist_push;

    rand_history_buf #(
        .WIDTH (WIDTH),
        .DEPTH (HISTORY)
    ) u_history (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (hist_push),
        .push_word (value_reg),
        .query     (work_reg[WIDTH-1:0]),
        .match     (hist_match)
    );

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg  <= IDLE;
            work_reg   <= '0;
            tries_reg  <= '0;
            value_reg  <= '0;
            forced_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            work_reg   <= work_next;
            tries_reg  <= tries_next;
            value_reg  <= value_next;
            forced_reg <= forced_next;
            valid_reg  <= valid_next;
        end
    end

    // Next-state and datapath update: capture, subtract, screen, hand off.
    always_comb begin
        state_next  = state_reg;
        work_next   = work_reg;
        tries_next  = tries_reg;
        value_next  = value_reg;
        forced_next = forced_reg;
        valid_next  = valid_reg;
        hist_push   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    work_next  = {1'b0, rnd_in};
                    tries_next = ONE_T;
                    state_next = REDUCE;
                end
            end

            REDUCE: begin
                // One subtraction per cycle keeps the datapath to a single
                // adder; the loop ends once the word is below RANGE.
                if (work_reg >= RANGE_W) begin
                    work_next = work_reg - RANGE_W;
                end else begin
                    state_next = CHECK;
                end
            end

            CHECK: begin
                if (hist_match && (tries_reg < MAX_T)) begin
                    // Repeat of a recent output: take whatever the LFSR shows
                    // right now and reduce it again.
                    work_next  = {1'b0, rnd_in};
                    tries_next = tries_reg + ONE_T;
                    state_next = REDUCE;
                end else begin
                    // Either fresh, or out of tries; a match here means the
                    // result is accepted anyway and flagged as forced.
                    value_next  = work_reg[WIDTH-1:0];
                    forced_next = hist_match;
                    valid_next  = 1'b1;
                    state_next  = DONE;
                end
            end

            DONE: begin
                // Any concurrent req is ignored; only ack moves us on.
                if (ack) begin
                    hist_push  = 1'b1;
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready  = (state_reg == IDLE);
    assign valid  = valid_reg;
    assign value  = value_reg;
    assign forced = forced_reg;

endmodule

// File: doc/rand_range_picker.md
Name: rand_range_picker

Overview:
- Consumes the free-running 10-bit pseudo-random word from the game's LFSR.
- On request, reduces the word into [0, RANGE) by sequential repeated subtraction.
- Rejects values equal to any of the last HISTORY accepted outputs, up to a retry bound.
- Returns the result over a valid/ack handshake; used for object spawn coordinates.

Parameters:
- WIDTH, 10, width of rnd_in and value
- RANGE, 600, exclusive upper bound of output; legal 1..2^WIDTH
- HISTORY, 4, number of past accepted outputs kept for repeat rejection; legal 1..8
- MAX_TRIES, 8, total samples per request before forced accept; legal ≥1

Ports:
- Clock  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- rnd_in  input  WIDTH  current LFSR word, sampled on capture edges
- req  input  1  request a new value; honoured only when ready=1
- ready  output  1  high in IDLE
- valid  output  1  result available; held until ack
- value  output  WIDTH  result, stable while valid=1
- forced  output  1  qualifies value; result accepted despite a history match (tries exhausted)
- ack  input  1  consumer accepted value; honoured only when valid=1

Behaviour:
- Reset (Clock edge with Reset=1): state=IDLE, ready=1, valid=0, value=0, forced=0. All history entry valid bits cleared; work and tries zeroed. Reset overrides every other input, including mid-REDUCE/CHECK/DONE; any in-flight request is dropped.
- States: IDLE, REDUCE, CHECK, DONE.
- IDLE: req=1 → work<=rnd_in, tries<=1, next=REDUCE. req=0 → stay.
- REDUCE:
  - work>=RANGE → work<=work-RANGE, stay.
  - else → CHECK.
  - One subtraction per cycle, so at most ceil(2^WIDTH/RANGE)-1 cycles.
  - Comparison and subtraction are unsigned at WIDTH+1 bits so RANGE=2^WIDTH works.
- CHECK: compare work against all valid history entries in parallel.
  - match && tries<MAX_TRIES → work<=rnd_in, tries<=tries+1, next=REDUCE. The resample is the LFSR word present this cycle.
  - match && tries==MAX_TRIES → value<=work, forced<=1, next=DONE.
  - no match → value<=work, forced<=0, next=DONE.
- DONE: valid=1.
  - ack=1 → push value into history (shift; oldest dropped; new entry marked valid), valid<=0, next=IDLE.
  - A forced value is also pushed.
- Latency, req edge to valid=1, with k subtractions and no retry: k+3 edges.
  - Example: rnd_in=700, RANGE=600 → valid high 4 edges after the req edge, value=100.
- Each retry adds (subtractions+2) edges.
- Simultaneous events:
  - req outside IDLE: ignored, not queued.
  - ack outside DONE: ignored.
  - req and ack both high in DONE: ack is processed and req is ignored; the requester re-asserts after ready returns.
- ready is combinational on state (state==IDLE); valid is registered.
- rnd_in=2^WIDTH-1 (XNOR-LFSR lock-up word) is a legal input and is reduced normally.
- History persists across requests and is cleared only by Reset.

Decomposition:
- Package rand_pkg holds:
  - the state enum (IDLE, REDUCE, CHECK, DONE);
  - default constants RAND_WIDTH=10, RAND_RANGE=600, RAND_HISTORY=4, RAND_MAX_TRIES=8.
- Sub-module rand_history_buf:
  - HISTORY-deep shift register with per-entry valid bits, push input and clear on Reset;
  - combinational match output for a query word.
- FSM and the reduce datapath stay in rand_range_picker.

Test Plan:
- Reset during DONE (valid=1), then after release req with rnd_in=100 → valid=0 on the reset edge; new request yields value=100, forced=0; history contains no stale value.
- RANGE=600, rnd_in=700, req one cycle, ack on first valid cycle → valid rises on 4th edge, value=100, forced=0; ready=1 the edge after ack.
- rnd_in=50 → value=50 on 3rd edge (no subtraction). Then rnd_in=1023 → value=423.
- After accepting 100, request with rnd_in held at 700 for all samples, MAX_TRIES=8 → 8 samples, value=100, forced=1. Request with rnd_in=700 at capture and 200 at first resample → value=200, forced=0.
- req held high continuously while valid held for 5 cycles without ack → value stable, no new capture. ack and req together → single return to IDLE; next request starts only on a later req edge.
- Accept 5 distinct values 10,20,30,40,50 with HISTORY=4, then request 10 → accepted with forced=0 (oldest evicted). Then request 50 → retry triggered.
